// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit core: program-counter geometry and sequencer states.
package cpu_pkg;

    localparam int              PC_W     = 8;
    localparam logic [PC_W-1:0] RESET_PC = 8'h00;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } seq_state_t;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO. Contents are never cleared; only the stack pointer resets.
module ret_stack #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;

    logic [W-1:0]   mem_q [DEPTH];
    logic [SPW-1:0] sp_q, sp_d;
    logic [AW-1:0]  wr_idx, top_idx;
    logic           do_push, do_pop;

    assign full    = (sp_q == SPW'(DEPTH));
    assign empty   = (sp_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && !full && !do_pop;
    assign wr_idx  = sp_q[AW-1:0];
    assign top_idx = sp_q[AW-1:0] - AW'(1);
    assign dout    = mem_q[top_idx];

    always_comb begin
        sp_d = sp_q;
        if (do_pop) begin
            sp_d = sp_q - SPW'(1);
        end else if (do_push) begin
            sp_d = sp_q + SPW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Next-PC generator: registered pc, RUN/HALT/FAULT control and a return-address stack.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int                       PC_W     = cpu_pkg::PC_W,
    parameter int                       DEPTH    = 4,
    parameter logic [cpu_pkg::PC_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch,
    input  logic [PC_W-1:0] offset,
    input  logic            call,
    input  logic            ret,
    input  logic [PC_W-1:0] target,
    input  logic            halt,
    output logic [PC_W-1:0] pc,
    output logic            stack_full,
    output logic            stack_empty,
    output logic            halted,
    output logic            fault
);

    seq_state_t      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] stk_top;
    logic            stk_push, stk_pop;
    logic            stk_full, stk_empty;

    assign pc_inc = pc_q + PC_W'(1);

    ret_stack #(
        .W     (PC_W),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_inc),
        .dout  (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // Priority: stall > halt > ret > call > branch > sequential.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        if (state_q == RUN && !stall) begin
            if (halt) begin
                state_d = HALT;
            end else if (ret) begin
                if (stk_empty) begin
                    state_d = FAULT;
                end else begin
                    pc_d    = stk_top;
                    stk_pop = 1'b1;
                end
            end else if (call) begin
                if (stk_full) begin
                    state_d = FAULT;
                end else begin
                    pc_d     = target;
                    stk_push = 1'b1;
                end
            end else if (branch) begin
                pc_d = pc_q + offset;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign pc          = pc_q;
    assign stack_full  = stk_full;
    assign stack_empty = stk_empty;
    assign halted      = (state_q == HALT);
    assign fault       = (state_q == FAULT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with hand-computed expected pc and flag values.
module tb_fetch_sequencer;

    logic       clk;
    logic       rst;
    logic       stall;
    logic       branch;
    logic [7:0] offset;
    logic       call;
    logic       ret;
    logic [7:0] target;
    logic       halt;
    logic [7:0] pc;
    logic       stack_full;
    logic       stack_empty;
    logic       halted;
    logic       fault;

    int unsigned n_checks;
    int unsigned n_errors;

    fetch_sequencer #(
        .PC_W     (8),
        .DEPTH    (4),
        .RESET_PC (8'h00)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .branch      (branch),
        .offset      (offset),
        .call        (call),
        .ret         (ret),
        .target      (target),
        .halt        (halt),
        .pc          (pc),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .halted      (halted),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst    = 1'b0;
        stall  = 1'b0;
        branch = 1'b0;
        offset = 8'h00;
        call   = 1'b0;
        ret    = 1'b0;
        target = 8'h00;
        halt   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic do_call(input logic [7:0] t);
        call = 1'b1; target = t;
        step();
        call = 1'b0; target = 8'h00;
    endtask

    // From reset: pc 01, then calls at 01,11,21,31 push 02,12,22,32.
    task automatic build4();
        do_reset();
        step();
        chk("b4_pc01", pc, 8'h01);
        do_call(8'h10); step();
        do_call(8'h20); step();
        do_call(8'h30); step();
        chk("b4_pc31", pc, 8'h31);
        do_call(8'h40);
        chk("b4_pc40", pc, 8'h40);
        chk("b4_full", stack_full, 1'b1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();

        // 1. reset, then free-running sequential fetch with wrap
        do_reset();
        chk("rst_pc", pc, 8'h00);
        chk("rst_empty", stack_empty, 1'b1);
        chk("rst_full", stack_full, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_fault", fault, 1'b0);
        for (int i = 1; i <= 260; i++) begin
            step();
            chk("seq_pc", pc, 32'(i % 256));
            chk("seq_flags", {stack_full, halted, fault, stack_empty}, 4'b0001);
        end

        // 2. relative branches, backwards and wrapping forwards
        do_reset();
        repeat (16) step();
        chk("br_pc10", pc, 8'h10);
        branch = 1'b1; offset = 8'hFC;
        step();
        chk("br_back", pc, 8'h0C);
        offset = 8'hE4;
        step();
        chk("br_to_f0", pc, 8'hF0);
        offset = 8'h20;
        step();
        chk("br_wrap", pc, 8'h10);
        offset = 8'h00;
        step();
        chk("br_self", pc, 8'h10);
        idle_inputs();

        // 3. call/return; ret beats call and branch when asserted together
        do_reset();
        repeat (5) step();
        chk("cr_pc05", pc, 8'h05);
        do_call(8'h40);
        chk("cr_call_pc", pc, 8'h40);
        chk("cr_call_empty", stack_empty, 1'b0);
        ret = 1'b1; call = 1'b1; target = 8'h99; branch = 1'b1; offset = 8'h33;
        step();
        idle_inputs();
        chk("cr_ret_pc", pc, 8'h06);
        chk("cr_ret_empty", stack_empty, 1'b1);
        chk("cr_fault", fault, 1'b0);

        // call at FF pushes 00
        do_reset();
        branch = 1'b1; offset = 8'hFF;
        step();
        branch = 1'b0;
        chk("cw_pcff", pc, 8'hFF);
        do_call(8'h55);
        ret = 1'b1;
        step();
        ret = 1'b0;
        chk("cw_ret00", pc, 8'h00);

        // 4. nested calls, overflow fault, then LIFO order after rebuild
        build4();
        do_call(8'h50);
        chk("ovf_fault", fault, 1'b1);
        chk("ovf_pc", pc, 8'h40);
        chk("ovf_full", stack_full, 1'b1);
        build4();
        ret = 1'b1;
        step(); chk("pop1", pc, 8'h32);
        step(); chk("pop2", pc, 8'h22);
        step(); chk("pop3", pc, 8'h12);
        step(); chk("pop4", pc, 8'h02);
        ret = 1'b0;
        chk("pop_empty", stack_empty, 1'b1);
        chk("pop_fault", fault, 1'b0);

        // 5. underflow fault is sticky until reset
        do_reset();
        ret = 1'b1;
        step();
        ret = 1'b0;
        chk("unf_fault", fault, 1'b1);
        chk("unf_pc", pc, 8'h00);
        branch = 1'b1; offset = 8'h05;
        step();
        branch = 1'b0;
        chk("unf_br_pc", pc, 8'h00);
        do_call(8'h40);
        chk("unf_call_pc", pc, 8'h00);
        chk("unf_call_empty", stack_empty, 1'b1);
        chk("unf_sticky", fault, 1'b1);
        do_reset();
        chk("unf_rst_fault", fault, 1'b0);
        chk("unf_rst_pc", pc, 8'h00);

        // 6. stall masks call; halt beats branch; reset exits HALT
        do_reset();
        repeat (2) step();
        stall = 1'b1; call = 1'b1; target = 8'h77;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stl_pc", pc, 8'h02);
            chk("stl_empty", stack_empty, 1'b1);
        end
        idle_inputs();
        step();
        chk("stl_release", pc, 8'h03);
        halt = 1'b1; branch = 1'b1; offset = 8'h10;
        step();
        halt = 1'b0;
        chk("hlt_halted", halted, 1'b1);
        chk("hlt_pc", pc, 8'h03);
        step();
        step();
        chk("hlt_frozen", pc, 8'h03);
        chk("hlt_nofault", fault, 1'b0);
        do_reset();
        chk("hlt_rst_pc", pc, 8'h00);
        chk("hlt_rst_halted", halted, 1'b0);
        step();
        chk("hlt_rst_run", pc, 8'h01);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
